instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming LEGv8-subset instruction encoder and instruction-memory loader, the producing end of the `controlSignal` decode path. It accepts one symbolic instruction per handshake: op, register fields and signed immediate. It packs these into the 32-bit machine word that the CPU's decoder expects and writes the words to consecutive instruction-memory addresses. It sits between the testbench/boot source and the instruction memory, so programs can be loaded without hand-assembled hex.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  reset is asynchronous and active-high.
- `start`  in  1  begin a load at address 0; honoured only in IDLE or DONE.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_op`  in  4  `instr_op_t`: B=0, BLT=1, BL=2, BR=3, CBZ=4, ADDI=5, ADDS=6, SUBS=7, LDUR=8, STUR=9.
- `in_rd`  in  5  Rd/Rt.
- `in_rn`  in  5  Rn.
- `in_rm`  in  5  Rm.
- `in_imm`  in  26  signed immediate: word offset for branches, byte offset for LDUR/STUR, unsigned for ADDI.
- `in_last`  in  1  final instruction of the program.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  encoded word.
- `busy`  out  1  high in LOAD and FLUSH.
- `done`  out  1  one-cycle pulse when the final word is written.
- `err`  out  1  sticky error; cleared by `start`.
- `count`  out  ADDR_W+1  words written since the last `start`.

## Operation
- States:
  - IDLE: `in_ready`=0; `start` goes to LOAD.
  - LOAD: `in_ready`=1; a handshake occurs when `in_valid && in_ready`.
  - FLUSH: write of the final word; next state is DONE.
  - DONE: `done` pulse; `start` goes to LOAD.
- The accept path is combinational encode, registered into `mem_wdata`/`mem_addr`. `mem_we`=1 the following cycle.
- Address counter: starts at 0 and increments per accept. `count` increments with each `mem_we`.
- Encodings (opcode in the high bits):
  - B: `000101`, imm26.
  - BL: `100101`, imm26.
  - BLT: `01010100`, imm19 in [23:5], cond `01011` in [4:0].
  - CBZ: `10110100`, imm19 in [23:5], Rt in [4:0].
  - BR: constant `0xD61F0000` with Rn in [9:5].
  - ADDI: `1001000100`, imm12 in [21:10], Rn, Rd.
  - ADDS: `10101011000`, Rm in [20:16], shamt=0, Rn, Rd.
  - SUBS: `11101011000`, Rm in [20:16], shamt=0, Rn, Rd.
  - LDUR: `11111000010`, imm9 in [20:12], `00` in [11:10], Rn, Rt.
  - STUR: `11111000000`, imm9 in [20:12], `00` in [11:10], Rn, Rt.
- Immediate range checks:
  - imm19: -2^18..2^18-1.
  - imm12: 0..4095.
  - imm9: -256..255.
  - Out of range: truncate to the field width (two's complement), write anyway, set `err`.
- Illegal `in_op` (10..15): write `0x00000000` and set `err`.
- Accepting a word with `in_last`=1 goes to FLUSH; `in_ready` drops the same cycle.
- Capacity: accepting at address 2**ADDR_W-1 without `in_last` also goes to FLUSH and sets `err` (overflow). No further words are accepted.
- `start` while in LOAD or FLUSH is ignored.
- `start` in DONE clears `err`, `count` and the address before the first accept.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `count` = 0.
- Reset is asynchronous: `mem_we` falls immediately, even mid-stream. No partial state survives.
- `start` at edge N: `in_ready`=1 from cycle N+1.
- Latency: an accept at edge K gives `mem_we`=1 with that word during cycle K+1.
- Throughput: one word per cycle; `in_valid` gaps produce `mem_we`=0 cycles.
- Last accept at edge K: FLUSH in cycle K+1 with final write; `done`=1 in cycle K+2, then `busy`=0.
- `count` is valid the cycle after each write and holds in DONE.

## Structure
- Package `instr_enc_pkg` holds:
  - `instr_op_t` enum;
  - opcode constants (`OPC_B`, `OPC_BLT`, ..., `OPC_STUR`);
  - `COND_LT`=5'b01011;
  - `BR_BASE`=32'hD61F0000;
  - state enum.
- Sub-module `instr_field_pack`: purely combinational. Maps op/regs/imm to `{word[31:0], range_err, op_err}`.
- Top: FSM, address/count counters, output registers.

## Test plan
- ADDI rd=1 rn=31 imm=5 with `in_last` -> addr 0, data `0x910017E1`; `done` 2 cycles after accept; `count`=1.
- ADDS then SUBS, both rd=3 rn=1 rm=2, back-to-back -> `0xAB020023` @0, `0xEB020023` @1, `mem_we` on two consecutive cycles.
- LDUR rt=4 rn=5 imm=-8 -> `0xF85F80A4`. STUR rt=4 rn=5 imm=8 -> `0xF80080A4`.
- Branch formats:
  - B imm=-1 -> `0x17FFFFFF`;
  - BL imm=3 -> `0x94000003`;
  - BR rn=30 -> `0xD61F03C0`;
  - CBZ rt=7 imm=-2 -> `0xB4FFFFC7`;
  - BLT imm=4 -> `0x5400008B`.
- ADDI rd=1 rn=31 imm=4096 -> `0x910003E1` written, `err`=1. Next `start` -> `err`=0.
- Overflow and reset:
  - ADDR_W=2, five words with `in_last` only on the 5th: four writes @0..3, `in_ready` low after the 4th accept, `done` pulse, `err`=1, `count`=4.
  - Separately, `reset` asserted mid-stream: `mem_we`=0 and all outputs 0 without waiting for an edge.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types and encoding constants for the LEGv8-subset instruction encoder.
package instr_enc_pkg;

  // Symbolic operations accepted on the input stream; 10..15 are illegal.
  typedef enum logic [3:0] {
    OpB    = 4'd0,
    OpBlt  = 4'd1,
    OpBl   = 4'd2,
    OpBr   = 4'd3,
    OpCbz  = 4'd4,
    OpAddi = 4'd5,
    OpAdds = 4'd6,
    OpSubs = 4'd7,
    OpLdur = 4'd8,
    OpStur = 4'd9
  } instr_op_t;

  // Opcode fields, left-aligned at bit 31 of the machine word.
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;
  localparam logic [7:0]  OPC_BLT  = 8'b01010100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // Condition code for B.LT in the conditional-branch Rt slot.
  localparam logic [4:0]  COND_LT  = 5'b01011;

  // BR with only the Rn field left open.
  localparam logic [31:0] BR_BASE  = 32'hD61F0000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction input stream plus instruction-memory write port.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Instruction source: drives fields, observes ready and the memory port.
  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: symbolic fields to a 32-bit machine word plus error flags.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rn_i,
  input  logic [4:0]  rm_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o,
  output logic        op_err_o
);

  logic fits19, fits12, fits9;

  // Signed fit: every bit above the field's sign bit must copy it.
  assign fits19 = (&imm_i[25:18]) | ~(|imm_i[25:18]);
  assign fits9  = (&imm_i[25:8])  | ~(|imm_i[25:8]);
  // ADDI immediate is unsigned.
  assign fits12 = ~(|imm_i[25:12]);

  // Field packing per operation; out-of-range immediates are truncated.
  always_comb begin
    word_o      = 32'd0;
    range_err_o = 1'b0;
    op_err_o    = 1'b0;
    unique case (op_i)
      OpB:    word_o = {OPC_B, imm_i};
      OpBl:   word_o = {OPC_BL, imm_i};
      OpBlt: begin
        word_o      = {OPC_BLT, imm_i[18:0], COND_LT};
        range_err_o = ~fits19;
      end
      OpCbz: begin
        word_o      = {OPC_CBZ, imm_i[18:0], rd_i};
        range_err_o = ~fits19;
      end
      OpBr:   word_o = BR_BASE | {22'd0, rn_i, 5'd0};
      OpAddi: begin
        word_o      = {OPC_ADDI, imm_i[11:0], rn_i, rd_i};
        range_err_o = ~fits12;
      end
      OpAdds: word_o = {OPC_ADDS, rm_i, 6'd0, rn_i, rd_i};
      OpSubs: word_o = {OPC_SUBS, rm_i, 6'd0, rn_i, rd_i};
      OpLdur: begin
        word_o      = {OPC_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        range_err_o = ~fits9;
      end
      OpStur: begin
        word_o      = {OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        range_err_o = ~fits9;
      end
      default: op_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts symbolic instructions and writes the
// packed words to consecutive instruction-memory addresses starting at 0.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  instr_encoder_if.slave  bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [ADDR_W:0] count_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        in_ready;
  logic        accept;
  logic        start_ok;
  logic        at_top;
  logic [31:0] word;
  logic        range_err;
  logic        op_err;

  instr_field_pack u_pack (
    .op_i        (bus.in_op),
    .rd_i        (bus.in_rd),
    .rn_i        (bus.in_rn),
    .rm_i        (bus.in_rm),
    .imm_i       (bus.in_imm),
    .word_o      (word),
    .range_err_o (range_err),
    .op_err_o    (op_err)
  );

  assign accept   = bus.in_valid & in_ready;
  assign start_ok = start_i & ((state_q == StIdle) | (state_q == StDone));
  // Last slot in memory: accepting here without in_last is an overflow.
  assign at_top   = &addr_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StLoad;
      StLoad:  if (accept && (bus.in_last || at_top)) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  if (start_ok) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state_q == StLoad);
    busy_o   = (state_q == StLoad) | (state_q == StFlush);
  end

  // Counters, sticky error and the registered memory write port.
  always_comb begin
    addr_d      = addr_q;
    count_d     = count_q + CntW'(mem_we_q);
    err_d       = err_q;
    done_d      = (state_q == StFlush);
    mem_we_d    = accept;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start_ok) begin
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
    if (accept) begin
      addr_d      = addr_q + ADDR_W'(1);
      mem_addr_d  = addr_q;
      mem_wdata_d = word;
      if (range_err || op_err || (at_top && !bus.in_last)) err_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, randomized programs against a
// arithmetic reference model, overflow on a tiny memory, and async reset.
module tb_instr_encoder;

  typedef struct {
    int op;
    int rd;
    int rn;
    int rm;
    int imm;
    bit last;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  logic start, start2;
  logic busy, done, err;
  logic [10:0] count;
  logic busy2, done2, err2;
  logic [2:0] count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ins_t        prog_q[$];
  logic [31:0] cap_data[$];
  int          cap_addr[$];
  int          cap_cyc[$];
  logic [31:0] cap2_data[$];
  int          cap2_addr[$];

  instr_encoder_if #(.ADDR_W(10)) bus ();
  instr_encoder_if #(.ADDR_W(2))  bus2 ();

  instr_encoder #(.ADDR_W(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .count_o (count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .start_i (start2),
    .bus     (bus2),
    .busy_o  (busy2),
    .done_o  (done2),
    .err_o   (err2),
    .count_o (count2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Record every memory write, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (bus.mem_we === 1'b1) begin
      cap_data.push_back(bus.mem_wdata);
      cap_addr.push_back(int'(bus.mem_addr));
      cap_cyc.push_back(cyc);
    end
    if (bus2.mem_we === 1'b1) begin
      cap2_data.push_back(bus2.mem_wdata);
      cap2_addr.push_back(int'(bus2.mem_addr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cap_w(input int i);
    return (i < cap_data.size()) ? cap_data[i] : 32'hxxxxxxxx;
  endfunction

  function automatic int cap_a(input int i);
    return (i < cap_addr.size()) ? cap_addr[i] : -1;
  endfunction

  // Non-negative residue of v modulo 2**w: two's-complement truncation.
  function automatic longint fld(input longint v, input int w);
    longint m;
    m = longint'(1) << w;
    return ((v % m) + m) % m;
  endfunction

  // Reference encoder built from the field layout with plain arithmetic.
  task automatic ref_encode(input ins_t s, output logic [31:0] w, output bit e);
    longint r;
    r = 0;
    e = 0;
    case (s.op)
      0: r = 64'h05 * (longint'(1) << 26) + fld(s.imm, 26);
      1: begin
        r = 64'h54 * (longint'(1) << 24) + fld(s.imm, 19) * 32 + 11;
        e = (s.imm < -(1 << 18)) || (s.imm > (1 << 18) - 1);
      end
      2: r = 64'h25 * (longint'(1) << 26) + fld(s.imm, 26);
      3: r = 64'hD61F0000 + s.rn * 32;
      4: begin
        r = 64'hB4 * (longint'(1) << 24) + fld(s.imm, 19) * 32 + s.rd;
        e = (s.imm < -(1 << 18)) || (s.imm > (1 << 18) - 1);
      end
      5: begin
        r = 64'h244 * (longint'(1) << 22) + fld(s.imm, 12) * 1024 + s.rn * 32 + s.rd;
        e = (s.imm < 0) || (s.imm > 4095);
      end
      6: r = 64'h558 * (longint'(1) << 21) + s.rm * 65536 + s.rn * 32 + s.rd;
      7: r = 64'h758 * (longint'(1) << 21) + s.rm * 65536 + s.rn * 32 + s.rd;
      8, 9: begin
        r = ((s.op == 8) ? 64'h7C2 : 64'h7C0) * (longint'(1) << 21)
            + fld(s.imm, 9) * 4096 + s.rn * 32 + s.rd;
        e = (s.imm < -256) || (s.imm > 255);
      end
      default: begin
        r = 0;
        e = 1;
      end
    endcase
    w = r[31:0];
  endtask

  function automatic ins_t mk(input int op, input int rd, input int rn, input int rm,
                              input int imm, input bit last);
    ins_t s;
    s.op = op; s.rd = rd; s.rn = rn; s.rm = rm; s.imm = imm; s.last = last;
    return s;
  endfunction

  function automatic ins_t rand_ins();
    ins_t s;
    int edges[11];
    logic [25:0] r26;
    edges = '{-(1 << 18), (1 << 18) - 1, 1 << 18, -(1 << 18) - 1, 4095, 4096,
              -256, 255, 256, -257, -1};
    s.op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                       : int'($urandom_range(0, 9));
    s.rd = $urandom_range(0, 31);
    s.rn = $urandom_range(0, 31);
    s.rm = $urandom_range(0, 31);
    case ($urandom_range(0, 3))
      0: s.imm = int'($urandom_range(0, 600)) - 300;
      1: s.imm = $urandom_range(0, 4095);
      2: begin
        r26 = 26'($urandom);
        s.imm = int'($signed(r26));
      end
      default: s.imm = edges[$urandom_range(0, 10)];
    endcase
    s.last = 0;
    return s;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input ins_t s);
    int n;
    n = 0;
    bus.in_op    = 4'(s.op);
    bus.in_rd    = 5'(s.rd);
    bus.in_rn    = 5'(s.rn);
    bus.in_rm    = 5'(s.rm);
    bus.in_imm   = 26'(s.imm);
    bus.in_last  = s.last;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load prog_q, then check flush/done timing, count, err and every write.
  task automatic run_prog(input int maxgap, input bit poke);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    bit e, exp_err;
    int n, g;
    exp_err = 0;
    foreach (prog_q[i]) begin
      ref_encode(prog_q[i], w, e);
      exp_w.push_back(w);
      exp_err |= e;
    end
    n = prog_q.size();
    cap_data.delete();
    cap_addr.delete();
    cap_cyc.delete();
    do_start();
    chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_cnt_clr", {21'd0, count}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxgap > 0) begin
        g = $urandom_range(0, maxgap);
        if (g > 0) begin
          bus.in_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      if (poke && i == 1) start = 1'b1;
      send(prog_q[i]);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("flush_we", {31'd0, bus.mem_we}, 32'd1);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    chk("flush_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_we", {31'd0, bus.mem_we}, 32'd0);
    chk("done_count", {21'd0, count}, 32'(n));
    chk("done_err", {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk("done_drop", {31'd0, done}, 32'd0);
    chk("count_hold", {21'd0, count}, 32'(n));
    chk("n_writes", 32'(cap_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk("wdata", cap_w(i), exp_w[i]);
      chk("waddr", 32'(cap_a(i)), 32'(i));
    end
  endtask

  initial begin
    ins_t s;
    logic [31:0] w;
    bit e;
    int len;

    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0;
    bus.in_rm = '0; bus.in_imm = '0; bus.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_rd = '0; bus2.in_rn = '0;
    bus2.in_rm = '0; bus2.in_imm = '0; bus2.in_last = 1'b0;

    #22;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_count", {21'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);

    // Single ADDI with last.
    prog_q = '{mk(5, 1, 31, 0, 5, 1)};
    run_prog(0, 0);
    chk("addi_word", cap_w(0), 32'h910017E1);

    // ADDS/SUBS back-to-back.
    prog_q = '{mk(6, 3, 1, 2, 0, 0), mk(7, 3, 1, 2, 0, 1)};
    run_prog(0, 0);
    chk("adds_word", cap_w(0), 32'hAB020023);
    chk("subs_word", cap_w(1), 32'hEB020023);
    if (cap_cyc.size() >= 2) chk("b2b_we", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
    else chk("b2b_we", 32'(cap_cyc.size()), 32'd2);

    // Loads/stores.
    prog_q = '{mk(8, 4, 5, 0, -8, 0), mk(9, 4, 5, 0, 8, 1)};
    run_prog(0, 0);
    chk("ldur_word", cap_w(0), 32'hF85F80A4);
    chk("stur_word", cap_w(1), 32'hF80080A4);

    // Branch formats, with a start pulse mid-load that must be ignored.
    prog_q = '{mk(0, 0, 0, 0, -1, 0), mk(2, 0, 0, 0, 3, 0), mk(3, 0, 30, 0, 0, 0),
               mk(4, 7, 0, 0, -2, 0), mk(1, 0, 0, 0, 4, 1)};
    run_prog(1, 1);
    chk("b_word", cap_w(0), 32'h17FFFFFF);
    chk("bl_word", cap_w(1), 32'h94000003);
    chk("br_word", cap_w(2), 32'hD61F03C0);
    chk("cbz_word", cap_w(3), 32'hB4FFFFC7);
    chk("blt_word", cap_w(4), 32'h5400008B);

    // ADDI out of range truncates and flags err; next start clears it.
    prog_q = '{mk(5, 1, 31, 0, 4096, 1)};
    run_prog(0, 0);
    chk("addi_trunc", cap_w(0), 32'h910003E1);
    chk("addi_err", {31'd0, err}, 32'd1);

    // Illegal op writes zero and flags err.
    prog_q = '{mk(6, 1, 2, 3, 0, 0), mk(12, 1, 2, 3, 0, 1)};
    run_prog(0, 0);
    chk("illegal_word", cap_w(1), 32'd0);

    // Randomized programs against the reference model.
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 8);
      prog_q.delete();
      for (int i = 0; i < len; i++) begin
        s = rand_ins();
        s.last = (i == len - 1);
        prog_q.push_back(s);
      end
      run_prog(2, ($urandom_range(0, 1) == 1));
    end

    // Overflow on a 4-word memory: fifth word never accepted.
    cap2_data.delete();
    cap2_addr.delete();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("ovf_ready", {31'd0, bus2.in_ready}, 32'd1);
    bus2.in_op = 4'd6; bus2.in_rn = 5'd1; bus2.in_rm = 5'd2; bus2.in_imm = '0;
    bus2.in_last = 1'b0;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.in_rd = 5'(i);
      @(negedge clk);
    end
    chk("ovf_ready_low", {31'd0, bus2.in_ready}, 32'd0);
    chk("ovf_we", {31'd0, bus2.mem_we}, 32'd1);
    chk("ovf_addr", {30'd0, bus2.mem_addr}, 32'd3);
    chk("ovf_err", {31'd0, err2}, 32'd1);
    bus2.in_rd = 5'd4;
    bus2.in_last = 1'b1;
    @(negedge clk);
    chk("ovf_done", {31'd0, done2}, 32'd1);
    chk("ovf_count", {29'd0, count2}, 32'd4);
    chk("ovf_err_hold", {31'd0, err2}, 32'd1);
    chk("ovf_no5th", {31'd0, bus2.in_ready}, 32'd0);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("ovf_nwrites", 32'(cap2_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ref_encode(mk(6, i, 1, 2, 0, 0), w, e);
      chk("ovf_wdata", (i < cap2_data.size()) ? cap2_data[i] : 32'hxxxxxxxx, w);
      chk("ovf_waddr", (i < cap2_addr.size()) ? 32'(cap2_addr[i]) : 32'hffffffff, 32'(i));
    end

    // Asynchronous reset mid-stream.
    do_start();
    send(mk(5, 1, 2, 0, -1, 0));
    send(mk(6, 5, 6, 7, 0, 0));
    chk("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("arst_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("arst_wdata", bus.mem_wdata, 32'd0);
    chk("arst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_count", {21'd0, count}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, bus.in_ready}, 32'd0);
    chk("post_rst_we", {31'd0, bus.mem_we}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
